// File: rtl/gpu_oam_dma_pkg.sv
// Shared constants, state encoding and source-page remap for the OAM DMA initiator.
// The remap folds the echo region (0xE0-0xFF) back onto WRAM.
package gpu_oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

  function automatic logic [7:0] src_page(input logic [7:0] value);
    return (value <= 8'hDF) ? value : value - 8'h20;
  endfunction

endpackage

// File: rtl/gpu_oam_dma.sv
// OAM DMA master: a write to 0xFF46 copies DMA_LEN bytes from page*0x100 into OAM.
// One dead cycle, then alternating READ/WRITE; a new register write restarts at once.
module gpu_oam_dma
  import gpu_oam_dma_pkg::*;
#(
  parameter int         DMA_LEN    = 160,
  parameter logic [7:0] OAM_BASE_H = 8'hFE
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oDMA,
  output logic        oBusRequest,
  output logic [15:0] oAddr,
  output logic        oWe,
  output logic [7:0]  oData,
  input  logic [7:0]  iData,
  output logic        oBusy
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] src_h;
  logic [7:0] idx;
  logic       detect;

  assign detect = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

  // A detect wins over every normal transition, including the final WRITE.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state <= ST_IDLE;
      oDMA  <= 8'h00;
      src_h <= 8'h00;
      idx   <= 8'h00;
    end else if (detect) begin
      state <= ST_START;
      oDMA  <= iCpuData;
      src_h <= src_page(iCpuData);
      idx   <= 8'h00;
    end else begin
      case (state)
        ST_START: state <= ST_READ;
        ST_READ:  state <= ST_WRITE;
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= ST_READ;
          end
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // The read data of the preceding READ arrives during WRITE and is forwarded as-is.
  always_comb begin
    oBusRequest = 1'b0;
    oAddr       = 16'h0000;
    oWe         = 1'b0;
    oData       = 8'h00;
    case (state)
      ST_START: oBusRequest = 1'b1;
      ST_READ: begin
        oBusRequest = 1'b1;
        oAddr       = {src_h, idx};
      end
      ST_WRITE: begin
        oBusRequest = 1'b1;
        oAddr       = {OAM_BASE_H, idx};
        oWe         = 1'b1;
        oData       = iData;
      end
      default: ;
    endcase
  end

  assign oBusy = oBusRequest;

endmodule

// File: tb/tb_gpu_oam_dma.sv
// Directed bench for gpu_oam_dma: a cycle-by-cycle bus check per transfer plus OAM content checks.
module tb_gpu_oam_dma;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oDMA;
  logic        oBusRequest;
  logic [15:0] oAddr;
  logic        oWe;
  logic [7:0]  oData;
  logic [7:0]  iData = 8'h00;
  logic        oBusy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] oam    [256];
  bit         oam_wr [256];
  logic       oam_clr = 1'b0;

  gpu_oam_dma dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iCpuAddr    (iCpuAddr),
    .iCpuWe      (iCpuWe),
    .iCpuData    (iCpuData),
    .oDMA        (oDMA),
    .oBusRequest (oBusRequest),
    .oAddr       (oAddr),
    .oWe         (oWe),
    .oData       (oData),
    .iData       (iData),
    .oBusy       (oBusy)
  );

  always #5 iClock = ~iClock;

  // Source memory contents: page C1 holds xx^5A; other pages differ by the page xor.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  // Synchronous memory: read data one cycle after the address; OAM writes captured.
  always @(posedge iClock) begin
    iData <= src_byte(oAddr);
    if (oam_clr) begin
      for (int k = 0; k < 256; k++) begin
        oam[k]    <= 8'h00;
        oam_wr[k] <= 1'b0;
      end
    end else if (oWe && oAddr[15:8] == 8'hFE) begin
      oam[oAddr[7:0]]    <= oData;
      oam_wr[oAddr[7:0]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic clear_oam();
    oam_clr = 1'b1;
    step();
    oam_clr = 1'b0;
  endtask

  // Presents a CPU access for the current cycle T; returns at T+1.
  task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d);
    iCpuAddr = a;
    iCpuWe   = we;
    iCpuData = d;
    step();
    iCpuAddr = 16'h0000;
    iCpuWe   = 1'b0;
    iCpuData = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".req"},  {31'd0, oBusRequest}, 32'd0);
    check({tag, ".busy"}, {31'd0, oBusy},       32'd0);
    check({tag, ".addr"}, {16'd0, oAddr},       32'd0);
    check({tag, ".we"},   {31'd0, oWe},         32'd0);
    check({tag, ".data"}, {24'd0, oData},       32'd0);
  endtask

  // Called at T+1. Checks every cycle up to the final WRITE at T+321 and,
  // unless stop_at_last is set, the return to IDLE at T+322.
  task automatic check_transfer(input string tag, input logic [7:0] page,
                                input logic [7:0] dma_val, input bit stop_at_last);
    logic [15:0] ra;
    check({tag, ".start.dma"},  {24'd0, oDMA},        {24'd0, dma_val});
    check({tag, ".start.req"},  {31'd0, oBusRequest}, 32'd1);
    check({tag, ".start.busy"}, {31'd0, oBusy},       32'd1);
    check({tag, ".start.addr"}, {16'd0, oAddr},       32'd0);
    check({tag, ".start.we"},   {31'd0, oWe},         32'd0);
    for (int i = 0; i < 160; i++) begin
      step();
      ra = {page, 8'(i)};
      check($sformatf("%s.rd%0d.addr", tag, i), {16'd0, oAddr},       {16'd0, ra});
      check($sformatf("%s.rd%0d.we", tag, i),   {31'd0, oWe},         32'd0);
      check($sformatf("%s.rd%0d.req", tag, i),  {31'd0, oBusRequest}, 32'd1);
      step();
      check($sformatf("%s.wr%0d.addr", tag, i), {16'd0, oAddr},       {16'hFE00 + 16'(i)});
      check($sformatf("%s.wr%0d.we", tag, i),   {31'd0, oWe},         32'd1);
      check($sformatf("%s.wr%0d.data", tag, i), {24'd0, oData},       {24'd0, src_byte(ra)});
      check($sformatf("%s.wr%0d.req", tag, i),  {31'd0, oBusRequest}, 32'd1);
    end
    if (!stop_at_last) begin
      step();
      check_idle({tag, ".end"});
    end
  endtask

  task automatic check_oam(input string tag, input logic [7:0] page);
    for (int i = 0; i < 160; i++)
      check($sformatf("%s.oam%0d", tag, i), {24'd0, oam[i]}, {24'd0, src_byte({page, 8'(i)})});
  endtask

  initial begin
    iReset   = 1'b0;
    iCpuAddr = 16'h0000;
    iCpuWe   = 1'b0;
    iCpuData = 8'h00;
    repeat (3) step();
    check_idle("rst");
    check("rst.dma", {24'd0, oDMA}, 32'd0);
    iReset = 1'b1;
    clear_oam();
    check_idle("post_rst");

    // Basic transfer from page C1.
    cpu_access(16'hFF46, 1'b1, 8'hC1);
    check_transfer("c1", 8'hC1, 8'hC1, 1'b0);
    check_oam("c1", 8'hC1);
    check("c1.oam9f", {24'd0, oam[8'h9F]}, {24'd0, 8'h9F ^ 8'h5A});
    check("c1.no_a0", {31'd0, oam_wr[8'hA0]}, 32'd0);
    check("c1.dma_hold", {24'd0, oDMA}, 32'h0000_00C1);

    // Echo remap: F0 reads from D0, DF stays at DF.
    clear_oam();
    cpu_access(16'hFF46, 1'b1, 8'hF0);
    check_transfer("f0", 8'hD0, 8'hF0, 1'b0);
    check_oam("f0", 8'hD0);
    clear_oam();
    cpu_access(16'hFF46, 1'b1, 8'hDF);
    check_transfer("df", 8'hDF, 8'hDF, 1'b0);

    // Restart during WRITE of index 0x40 (T+131).
    clear_oam();
    cpu_access(16'hFF46, 1'b1, 8'h80);
    repeat (130) step();
    check("rs.wr40.addr", {16'd0, oAddr}, 32'h0000_FE40);
    check("rs.wr40.we",   {31'd0, oWe},   32'd1);
    cpu_access(16'hFF46, 1'b1, 8'h90);
    check_transfer("rs", 8'h90, 8'h90, 1'b0);
    check_oam("rs", 8'h90);

    // Detect on the same edge as the final WRITE: goes to START, not IDLE.
    clear_oam();
    cpu_access(16'hFF46, 1'b1, 8'hC1);
    check_transfer("lastA", 8'hC1, 8'hC1, 1'b1);
    cpu_access(16'hFF46, 1'b1, 8'hA5);
    check_transfer("lastB", 8'hA5, 8'hA5, 1'b0);
    check("lastB.oam9f", {24'd0, oam[8'h9F]}, {24'd0, src_byte(16'hA59F)});

    // Reset during WRITE of index 0x10 (T+35); detects ignored while in reset.
    clear_oam();
    cpu_access(16'hFF46, 1'b1, 8'hC1);
    repeat (34) step();
    check("mr.wr10.addr", {16'd0, oAddr}, 32'h0000_FE10);
    iReset = 1'b0;
    step();
    check_idle("mr.idle");
    check("mr.dma", {24'd0, oDMA}, 32'd0);
    cpu_access(16'hFF46, 1'b1, 8'hC1);
    check_idle("mr.ignored");
    check("mr.ignored.dma", {24'd0, oDMA}, 32'd0);
    iReset = 1'b1;
    repeat (10) step();
    check_idle("mr.after");
    check("mr.fe10", {31'd0, oam_wr[8'h10]}, 32'd1);
    check("mr.fe11", {31'd0, oam_wr[8'h11]}, 32'd0);

    // Accesses that must not trigger a transfer.
    cpu_access(16'hFF45, 1'b1, 8'h33);
    check_idle("ff45");
    check("ff45.dma", {24'd0, oDMA}, 32'd0);
    cpu_access(16'hFF47, 1'b1, 8'h44);
    check_idle("ff47");
    check("ff47.dma", {24'd0, oDMA}, 32'd0);
    cpu_access(16'hFF46, 1'b0, 8'h55);
    check_idle("ff46rd");
    check("ff46rd.dma", {24'd0, oDMA}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
